// File: rtl/mux2_rr_arbiter_if.sv
// Request/grant/data bundle between two requesters and the shared mux2 arbiter.
// A transfer happens in any cycle where gnt_x and req_x are both high; data of that side is captured at the next edge.
interface mux2_rr_arbiter_if #(
  parameter int W = 1
);
  logic         req_a;
  logic         req_b;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         gnt_a;
  logic         gnt_b;
  logic         s;
  logic [W-1:0] o;
  logic         o_valid;
  logic         last;

  modport master (
    output req_a, req_b, a, b,
    input  gnt_a, gnt_b, s, o, o_valid, last
  );

  modport slave (
    input  req_a, req_b, a, b,
    output gnt_a, gnt_b, s, o, o_valid, last
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one mux2 between requesters A and B, with a burst cap
// and a registered mux output.
module mux2_rr_arbiter #(
  parameter int W         = 1,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3,
  parameter bit FIRST_PRI = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mux2_rr_arbiter_if.slave bus,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pri_q, pri_d;
  logic             s_q, s_d;
  logic [W-1:0]     o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic             xfer;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pri_q     <= FIRST_PRI;
      s_q       <= 1'b0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pri_q     <= pri_d;
      s_q       <= s_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
    end
  end

  // pri_q: 0 prefers A, 1 prefers B; only consulted when both request from IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pri_d   = pri_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req_a && (!bus.req_b || !pri_q)) begin
          state_d = GRANT_A;
          cnt_d   = CNT_ONE;
        end else if (bus.req_b) begin
          state_d = GRANT_B;
          cnt_d   = CNT_ONE;
        end
      end
      GRANT_A: begin
        if (!bus.req_a) begin
          pri_d = 1'b1;
          if (bus.req_b) begin
            state_d = GRANT_B;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (bus.req_b) begin
          state_d = GRANT_B;
          cnt_d   = CNT_ONE;
          pri_d   = 1'b0;
        end
      end
      GRANT_B: begin
        if (!bus.req_b) begin
          pri_d = 1'b0;
          if (bus.req_a) begin
            state_d = GRANT_A;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (bus.req_a) begin
          state_d = GRANT_A;
          cnt_d   = CNT_ONE;
          pri_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Select follows the granted side and is left alone in IDLE to avoid toggling the mux.
  always_comb begin
    s_d = s_q;
    if (state_d == GRANT_A) begin
      s_d = 1'b0;
    end else if (state_d == GRANT_B) begin
      s_d = 1'b1;
    end
  end

  always_comb begin
    xfer      = ((state_q == GRANT_A) && bus.req_a) || ((state_q == GRANT_B) && bus.req_b);
    o_valid_d = xfer;
    o_d       = o_q;
    if (xfer) begin
      o_d = s_q ? bus.b : bus.a;
    end
  end

  assign bus.gnt_a   = (state_q == GRANT_A);
  assign bus.gnt_b   = (state_q == GRANT_B);
  assign bus.s       = s_q;
  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;
  assign bus.last    = (state_q != IDLE) && (cnt_q == CNT_MAX);
  assign state_o     = state_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed vector tables, hand sequences and a randomized
// run scored against a behavioural arbitration model.
module tb_mux2_rr_arbiter;
  localparam int W    = 1;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.W(W)) bus0 ();
  mux2_rr_arbiter_if #(.W(W)) bus1 ();
  logic [1:0] st0, st1;

  mux2_rr_arbiter #(.W(W), .MAX_BURST(MAXB), .CNT_W(3), .FIRST_PRI(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0), .state_o(st0)
  );

  mux2_rr_arbiter #(.W(W), .MAX_BURST(1), .CNT_W(3), .FIRST_PRI(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1), .state_o(st1)
  );

  int checks = 0;
  int errors = 0;

  // Output word layout: {2'b00, gnt_a, gnt_b, s, o, o_valid, last}
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic pre_rst;
    logic ra;
    logic rb;
    logic a;
    logic b;
    logic ga;
    logic gb;
    logic s;
    logic o;
    logic ov;
    logic last;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] outs0();
    return {2'b00, bus0.gnt_a, bus0.gnt_b, bus0.s, bus0.o, bus0.o_valid, bus0.last};
  endfunction

  function automatic logic [7:0] outs1();
    return {2'b00, bus1.gnt_a, bus1.gnt_b, bus1.s, bus1.o, bus1.o_valid, bus1.last};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b ({gnt_a,gnt_b,s,o,o_valid,last})", name, got[5:0], exp[5:0]);
    end
  endtask

  task automatic drive0(input logic ra, input logic rb, input logic [W-1:0] a, input logic [W-1:0] b);
    bus0.req_a = ra;
    bus0.req_b = rb;
    bus0.a     = a;
    bus0.b     = b;
  endtask

  task automatic drive1(input logic ra, input logic rb, input logic [W-1:0] a, input logic [W-1:0] b);
    bus1.req_a = ra;
    bus1.req_b = rb;
    bus1.a     = a;
    bus1.b     = b;
  endtask

  // Called just after a negative edge; reset pulse completes well before the next rising edge.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  int           hold;         // -1 nobody, 0 A, 1 B
  int           run;          // cycles the current holder has owned the mux
  int           last_holder;  // side that most recently let go; -1 since reset
  logic         m_s;
  logic [W-1:0] m_o;
  logic         m_ov;
  logic         m_req[2];
  logic [W-1:0] m_dat[2];

  task automatic model_reset();
    hold        = -1;
    run         = 0;
    last_holder = -1;
    m_s         = 1'b0;
    m_o         = '0;
    m_ov        = 1'b0;
  endtask

  task automatic model_step();
    int nxt;
    if (hold >= 0 && m_req[hold]) begin
      m_o  = m_dat[hold];
      m_ov = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
    nxt = hold;
    if (hold < 0) begin
      if (m_req[0] && m_req[1]) nxt = (last_holder < 0) ? 0 : 1 - last_holder;
      else if (m_req[0]) nxt = 0;
      else if (m_req[1]) nxt = 1;
      run = 1;
    end else if (!m_req[hold]) begin
      last_holder = hold;
      nxt = m_req[1-hold] ? 1 - hold : -1;
      run = 1;
    end else if (run < MAXB) begin
      run++;
    end else if (m_req[1-hold]) begin
      nxt = 1 - hold;
      run = 1;
    end
    hold = nxt;
    if (hold >= 0) m_s = (hold == 1);
  endtask

  function automatic logic [7:0] model_outs();
    return {2'b00, hold == 0, hold == 1, m_s, m_o, m_ov, (hold >= 0) && (run == MAXB)};
  endfunction

  initial begin
    vec_t v;
    logic [7:0] e;
    logic ra, rb;
    logic [W-1:0] da, db;

    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    pulse_reset();
    check("reset_outs0", outs0(), 8'd0);
    check("reset_state0", {6'd0, st0}, 8'd0);
    check("reset_outs1", outs1(), 8'd0);

    // Fields: pre_rst | ra rb | a b | ga gb s | o ov last
    // Single requester A, three request cycles, then idle.
    vecs.push_back(vec_t'(11'b1_10_10_100_000));
    vecs.push_back(vec_t'(11'b0_10_10_100_110));
    vecs.push_back(vec_t'(11'b0_10_10_100_110));
    vecs.push_back(vec_t'(11'b0_00_10_000_100));
    vecs.push_back(vec_t'(11'b0_00_00_000_100));
    // Both requesting, A=0 B=1: 4-cycle bursts alternating with no gap.
    vecs.push_back(vec_t'(11'b1_11_01_100_000));
    vecs.push_back(vec_t'(11'b0_11_01_100_010));
    vecs.push_back(vec_t'(11'b0_11_01_100_010));
    vecs.push_back(vec_t'(11'b0_11_01_100_011));
    vecs.push_back(vec_t'(11'b0_11_01_011_010));
    vecs.push_back(vec_t'(11'b0_11_01_011_110));
    vecs.push_back(vec_t'(11'b0_11_01_011_110));
    vecs.push_back(vec_t'(11'b0_11_01_011_111));
    vecs.push_back(vec_t'(11'b0_11_01_100_110));
    vecs.push_back(vec_t'(11'b0_11_01_100_010));
    // A alone past the cap: saturates with LAST held, then B arrives.
    vecs.push_back(vec_t'(11'b1_10_10_100_000));
    vecs.push_back(vec_t'(11'b0_10_10_100_110));
    vecs.push_back(vec_t'(11'b0_10_10_100_110));
    vecs.push_back(vec_t'(11'b0_10_10_100_111));
    vecs.push_back(vec_t'(11'b0_10_10_100_111));
    vecs.push_back(vec_t'(11'b0_10_10_100_111));
    vecs.push_back(vec_t'(11'b0_10_10_100_111));
    vecs.push_back(vec_t'(11'b0_11_10_011_110));
    vecs.push_back(vec_t'(11'b0_01_10_011_010));
    // B burst, IDLE, both request -> A; A drops -> B with one non-transfer cycle.
    vecs.push_back(vec_t'(11'b1_01_01_011_000));
    vecs.push_back(vec_t'(11'b0_01_01_011_110));
    vecs.push_back(vec_t'(11'b0_00_01_001_100));
    vecs.push_back(vec_t'(11'b0_11_01_100_100));
    vecs.push_back(vec_t'(11'b0_11_01_100_010));
    vecs.push_back(vec_t'(11'b0_11_01_100_010));
    vecs.push_back(vec_t'(11'b0_01_01_011_000));
    vecs.push_back(vec_t'(11'b0_01_01_011_110));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.pre_rst) pulse_reset();
      drive0(v.ra, v.rb, v.a, v.b);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs0(), {2'b00, v.ga, v.gb, v.s, v.o, v.ov, v.last});
    end

    // Async reset while B holds the mux, then a fresh contest goes to A.
    pulse_reset();
    drive0(1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_pre_grant_b", outs0(), {2'b00, 6'b011_110});
    #1 rst = 1'b1;
    #1;
    check("rst_async_outs", outs0(), 8'd0);
    check("rst_async_state", {6'd0, st0}, 8'd0);
    rst = 1'b0;
    drive0(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("rst_then_a_wins", outs0(), {2'b00, 6'b100_000});

    // MAX_BURST=1 instance: strict alternation, LAST always set.
    drive0(1'b0, 1'b0, '0, '0);
    pulse_reset();
    drive1(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      e = {2'b00, (i % 2) == 0, (i % 2) == 1, (i % 2) == 1, (i > 0) && ((i % 2) == 1), i > 0, 1'b1};
      check($sformatf("burst1_cyc%0d", i), outs1(), e);
    end
    drive1(1'b0, 1'b0, '0, '0);

    // Randomized run against the model, with occasional mid-run resets.
    pulse_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        #1;
        check($sformatf("rand_rst%0d", i), outs0(), 8'd0);
        rst = 1'b0;
        model_reset();
      end
      ra = ($urandom_range(0, 9) < 7);
      rb = ($urandom_range(0, 9) < 6);
      da = W'($urandom);
      db = W'($urandom);
      drive0(ra, rb, da, db);
      m_req[0] = ra;
      m_req[1] = rb;
      m_dat[0] = da;
      m_dat[1] = db;
      @(posedge clk);
      model_step();
      exp_q.push_back(model_outs());
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rand%0d: no expected entry queued", i);
      end else begin
        check($sformatf("rand%0d", i), outs0(), exp_q.pop_front());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
